sobel_dispatch: RTL and testbench
=================================

Name: sobel_dispatch

Overview:
- Scheduler that shares a pool of p_units identical Sobel kernel units (3x3 window in, one p_data_bits result out, busy_out/valid_in/valid_out handshake) behind a single kernel-style port.
- Accepts windows from the line-buffer side and issues them round-robin to free units. Returns results strictly in acceptance order through a per-unit result slot and an in-order tag FIFO.
- Sits between the window generator and the gradient-magnitude stage. Multi-cycle kernels run in parallel and sustain up to one window per cycle.

Parameters:
- p_data_bits, 8, pixel and result width.
- p_units, 4, number of kernel units in the pool (2..16).
- p_idx_bits, 2, unit index width; must equal clog2(p_units).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- busy_out  out  1  high = no window can be accepted this cycle; combinational.
- valid_in  in  1  window present; accepted when valid_in && !busy_out.
- data_in  in  9*p_data_bits  3x3 window, same packing as kernel units.
- valid_out  out  1  one-cycle pulse, result on data_out.
- data_out  out  p_data_bits  result, in acceptance order.
- unit_valid_in  out  p_units  one-hot issue strobe per unit.
- unit_data  out  9*p_data_bits  registered window, shared by all units.
- unit_busy  in  p_units  unit busy_out flags.
- unit_valid_out  in  p_units  unit result strobes.
- unit_data_out  in  p_units*p_data_bits  unit results; unit k at bits [k*p_data_bits +: p_data_bits].
- inflight_out  out  p_idx_bits+1  number of windows accepted but not yet retired.
- err_out  out  1  sticky: result strobe from a unit with no outstanding window.

Behaviour:
- Reset values:
  - busy_out = 0 once reset has released and a unit is free.
  - valid_out = 0, data_out = 0, unit_valid_in = 0, unit_data = 0, inflight_out = 0, err_out = 0.
  - All inflight flags, slot-full flags and the tag FIFO are cleared; the round-robin pointer is 0.
- Per-unit state: inflight[k] is set on issue and cleared on retirement. slot[k] and slot_full[k] hold the captured result.
- Free unit: !inflight[k] && !unit_busy[k]. busy_out = no free unit OR i_rst.
- Grant: the first free unit at or after the rr pointer, wrapping modulo p_units. On accept, rr <= grant+1 modulo p_units.
- Issue latency: accept at edge t. At t+1, unit_data = captured window and unit_valid_in[grant] = 1 for exactly one cycle. inflight[grant] is set at t. The grant index is pushed to the tag FIFO (depth p_units; it cannot overflow because inflight bounds it).
- Capture: unit_valid_out[k] && inflight[k] && !slot_full[k] loads slot[k] and sets slot_full[k] at the next edge.
- Stray strobe: unit_valid_out[k] with !inflight[k], or with slot_full[k] already set, is ignored and sets err_out until reset.
- Retire: when the tag FIFO is non-empty and slot_full[head] is set, at the next edge:
  - valid_out = 1 and data_out = slot[head];
  - head is popped; slot_full[head] and inflight[head] are cleared.
- At most one retire per cycle. Result latency is 2 cycles after unit_valid_out for the head unit.
- Out-of-order completion: a non-head unit's result waits in its slot; that unit stays non-free until it retires.
- Simultaneous events:
  - Accept, capture and retire may all occur in one cycle.
  - A unit retired this cycle is not free until the next cycle.
  - inflight_out = pushes - pops, updated each edge.
- data_out holds its last value when valid_out = 0. No downstream backpressure.
- Reset mid-operation: all windows in flight are discarded. Units must be reset on the same i_rst. Results arriving after reset set err_out.
- p_units = 1 degenerates to a serial wrapper: one window outstanding, busy_out high from accept to retire.

Test Plan:
- Single window, bench units with a fixed latency of 18 cycles, unit 0 returns 0x5A -> unit_valid_in = 4'b0001 one cycle after accept; valid_out with data_out = 0x5A exactly 2 cycles after unit_valid_out[0]; inflight_out returns to 0.
- Back-to-back: 6 windows on consecutive cycles, 4 units -> grants 0,1,2,3; busy_out high after the 4th accept; the 5th window is accepted the cycle after the first retirement and goes to unit 0; outputs appear in order 1..6.
- Out-of-order completion: units 0..3 with latencies 20,5,5,5 returning A,B,C,D -> no valid_out until unit 0 completes, then A,B,C,D on 4 consecutive cycles.
- Round-robin skip: unit 1 held busy externally, 3 windows -> grants 0,2,3; rr pointer wraps correctly on the next window.
- Stray strobe: pulse unit_valid_out[2] with nothing outstanding -> err_out = 1 and stays high, no valid_out; err_out clears after i_rst.
- Reset with 3 windows in flight -> the next cycle has valid_out = 0, inflight_out = 0, busy_out = 0; a new window is granted to unit 0.

Source files
------------

// File: rtl/sobel_dispatch_if.sv
// Bundle of the dispatcher's kernel-style port and its pool-facing port.
// master = dispatcher side, slave = window source / sink / kernel pool side.
interface sobel_dispatch_if #(
    parameter int p_data_bits = 8,
    parameter int p_units     = 4,
    parameter int p_idx_bits  = 2
);
    logic                             busy_out;
    logic                             valid_in;
    logic [9*p_data_bits-1:0]         data_in;
    logic                             valid_out;
    logic [p_data_bits-1:0]           data_out;
    logic [p_units-1:0]               unit_valid_in;
    logic [9*p_data_bits-1:0]         unit_data;
    logic [p_units-1:0]               unit_busy;
    logic [p_units-1:0]               unit_valid_out;
    logic [p_units*p_data_bits-1:0]   unit_data_out;
    logic [p_idx_bits:0]              inflight_out;
    logic                             err_out;

    modport master (
        output busy_out, valid_out, data_out, unit_valid_in, unit_data, inflight_out, err_out,
        input  valid_in, data_in, unit_busy, unit_valid_out, unit_data_out
    );

    modport slave (
        input  busy_out, valid_out, data_out, unit_valid_in, unit_data, inflight_out, err_out,
        output valid_in, data_in, unit_busy, unit_valid_out, unit_data_out
    );
endinterface

// File: rtl/sobel_dispatch.sv
// Round-robin dispatcher sharing a pool of Sobel kernel units behind one port;
// results are parked per unit and retired in acceptance order via a tag FIFO.
module sobel_dispatch #(
    parameter int p_data_bits = 8,
    parameter int p_units     = 4,
    parameter int p_idx_bits  = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    sobel_dispatch_if.master bus
);
    localparam int lp_iw = (p_idx_bits < 1) ? 1 : p_idx_bits;
    localparam int lp_cw = p_idx_bits + 1;
    localparam int lp_ww = 9 * p_data_bits;

    typedef logic [lp_iw-1:0] idx_t;
    typedef logic [lp_cw-1:0] cnt_t;

    logic [p_units-1:0]     inflight_q, inflight_d;
    logic [p_units-1:0]     slot_full_q, slot_full_d;
    logic [p_data_bits-1:0] slot_q [p_units];
    logic [p_data_bits-1:0] slot_d [p_units];
    idx_t                   tag_q [p_units];
    idx_t                   tag_d [p_units];
    idx_t                   rr_q, rr_d, head_q, head_d, tail_q, tail_d;
    cnt_t                   count_q, count_d;
    logic                   valid_out_q, valid_out_d;
    logic [p_data_bits-1:0] data_out_q, data_out_d;
    logic [p_units-1:0]     unit_valid_in_q, unit_valid_in_d;
    logic [lp_ww-1:0]       unit_data_q, unit_data_d;
    logic                   err_q, err_d;

    logic [p_units-1:0]     free;
    logic                   found, busy, accept, retire;
    idx_t                   grant, head_unit;

    function automatic idx_t wrap_add(idx_t base, int off);
        return idx_t'((int'(base) + off) % p_units);
    endfunction

    assign free      = ~inflight_q & ~bus.unit_busy;
    assign head_unit = tag_q[head_q];
    assign retire    = (count_q != '0) && slot_full_q[head_unit];
    assign busy      = !found || i_rst;
    assign accept    = bus.valid_in && !busy;

    // First free unit at or after the round-robin pointer.
    always_comb begin
        grant = rr_q;
        found = 1'b0;
        for (int i = 0; i < p_units; i++) begin
            if (!found && free[wrap_add(rr_q, i)]) begin
                grant = wrap_add(rr_q, i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        inflight_d      = inflight_q;
        slot_full_d     = slot_full_q;
        slot_d          = slot_q;
        tag_d           = tag_q;
        rr_d            = rr_q;
        head_d          = head_q;
        tail_d          = tail_q;
        valid_out_d     = 1'b0;
        data_out_d      = data_out_q;
        unit_valid_in_d = '0;
        unit_data_d     = unit_data_q;
        err_d           = err_q;

        // A strobe is only legal from a unit that owns a window and has an empty slot.
        for (int k = 0; k < p_units; k++) begin
            if (bus.unit_valid_out[k]) begin
                if (inflight_q[k] && !slot_full_q[k]) begin
                    slot_full_d[k] = 1'b1;
                    slot_d[k]      = bus.unit_data_out[k*p_data_bits +: p_data_bits];
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        if (retire) begin
            valid_out_d            = 1'b1;
            data_out_d             = slot_q[head_unit];
            slot_full_d[head_unit] = 1'b0;
            inflight_d[head_unit]  = 1'b0;
            head_d                 = wrap_add(head_q, 1);
        end

        if (accept) begin
            inflight_d[grant]      = 1'b1;
            tag_d[tail_q]          = grant;
            tail_d                 = wrap_add(tail_q, 1);
            rr_d                   = wrap_add(grant, 1);
            unit_valid_in_d[grant] = 1'b1;
            unit_data_d            = bus.data_in;
        end

        count_d = count_q + cnt_t'(accept) - cnt_t'(retire);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            inflight_q      <= '0;
            slot_full_q     <= '0;
            rr_q            <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            valid_out_q     <= 1'b0;
            data_out_q      <= '0;
            unit_valid_in_q <= '0;
            unit_data_q     <= '0;
            err_q           <= 1'b0;
        end else begin
            inflight_q      <= inflight_d;
            slot_full_q     <= slot_full_d;
            rr_q            <= rr_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            valid_out_q     <= valid_out_d;
            data_out_q      <= data_out_d;
            unit_valid_in_q <= unit_valid_in_d;
            unit_data_q     <= unit_data_d;
            err_q           <= err_d;
        end
    end

    // Slot and tag storage is qualified by the flags above, so it needs no reset.
    always_ff @(posedge i_clk) begin
        slot_q <= slot_d;
        tag_q  <= tag_d;
    end

    assign bus.busy_out      = busy;
    assign bus.valid_out     = valid_out_q;
    assign bus.data_out      = data_out_q;
    assign bus.unit_valid_in = unit_valid_in_q;
    assign bus.unit_data     = unit_data_q;
    assign bus.inflight_out  = count_q;
    assign bus.err_out       = err_q;
endmodule

// File: tb/tb_sobel_dispatch.sv
// Bench for sobel_dispatch: behavioural kernel pool with per-unit latency,
// in-order scoreboard, and directed scenarios for the dispatcher.
module tb_sobel_dispatch;
    localparam int DW = 8;
    localparam int NU = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sobel_dispatch_if #(.p_data_bits(DW), .p_units(NU), .p_idx_bits(IW)) bus ();

    sobel_dispatch #(.p_data_bits(DW), .p_units(NU), .p_idx_bits(IW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.master)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Kernel pool model: each unit echoes the centre pixel after lat[k] cycles.
    int              lat [NU];
    int              cnt [NU];
    logic [DW-1:0]   res [NU];
    logic [NU-1:0]   uvo;
    logic [NU-1:0]   stray;
    logic [NU-1:0]   force_busy;

    always @(posedge clk) begin
        for (int k = 0; k < NU; k++) begin
            if (rst) begin
                cnt[k] <= 0;
                uvo[k] <= 1'b0;
                res[k] <= '0;
            end else begin
                uvo[k] <= 1'b0;
                if (bus.unit_valid_in[k]) begin
                    cnt[k] <= lat[k];
                    res[k] <= bus.unit_data[4*DW +: DW];
                end else if (cnt[k] == 1) begin
                    cnt[k] <= 0;
                    uvo[k] <= 1'b1;
                end else if (cnt[k] > 1) begin
                    cnt[k] <= cnt[k] - 1;
                end
            end
        end
    end

    always_comb begin
        bus.unit_data_out = '0;
        bus.unit_busy     = '0;
        for (int k = 0; k < NU; k++) begin
            bus.unit_data_out[k*DW +: DW] = res[k];
            bus.unit_busy[k]              = (cnt[k] != 0) || force_busy[k];
        end
    end
    assign bus.unit_valid_out = uvo | stray;

    // Scoreboard and event logs
    logic [DW-1:0] exp_q[$];
    int            grant_log[$];
    int            vo_cyc[$];
    int            uvo_cyc [NU];

    always @(posedge clk) begin
        cyc++;
        if (rst) exp_q.delete();
        else if (bus.valid_in && !bus.busy_out) exp_q.push_back(bus.data_in[4*DW +: DW]);
    end

    always @(negedge clk) begin
        if (bus.unit_valid_in != '0) begin
            chk("uvi_onehot", 32'($onehot(bus.unit_valid_in)), 32'd1);
            for (int k = 0; k < NU; k++) if (bus.unit_valid_in[k]) grant_log.push_back(k);
        end
        for (int k = 0; k < NU; k++) if (bus.unit_valid_out[k]) uvo_cyc[k] = cyc;
        if (bus.valid_out === 1'b1) begin
            vo_cyc.push_back(cyc);
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("sb_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.valid_in = 1'b0;
        tick();
        chk("busy_in_reset", 32'(bus.busy_out), 32'd1);
        tick();
        rst = 1'b0;
        #1;
        grant_log.delete();
        vo_cyc.delete();
        for (int k = 0; k < NU; k++) uvo_cyc[k] = -1;
        chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
        chk("rst_data_out", 32'(bus.data_out), 32'd0);
        chk("rst_uvi", 32'(bus.unit_valid_in), 32'd0);
        chk("rst_unit_data", 32'(bus.unit_data[31:0]), 32'd0);
        chk("rst_inflight", 32'(bus.inflight_out), 32'd0);
        chk("rst_err", 32'(bus.err_out), 32'd0);
        chk("rst_busy", 32'(bus.busy_out), 32'd0);
    endtask

    task automatic send(input logic [DW-1:0] centre, output int acc);
        logic ok;
        ok  = 1'b0;
        acc = -1;
        bus.valid_in = 1'b1;
        for (int p = 0; p < 9; p++) bus.data_in[p*DW +: DW] = (p == 4) ? centre : DW'($urandom);
        for (int i = 0; i < 300 && !ok; i++) begin
            #1;
            if (!bus.busy_out) begin
                acc = cyc;
                ok  = 1'b1;
            end
            tick();
        end
        bus.valid_in = 1'b0;
        if (!ok) chk("send_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_vo(input int n, input string tag);
        for (int i = 0; i < 500 && vo_cyc.size() < n; i++) tick();
        chk(tag, 32'(vo_cyc.size() >= n), 32'd1);
    endtask

    task automatic set_lat(input int a, input int b, input int c, input int d);
        lat[0] = a; lat[1] = b; lat[2] = c; lat[3] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc [7];
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        stray        = '0;
        force_busy   = '0;
        set_lat(18, 18, 18, 18);

        // Single window
        do_reset();
        send(8'h5A, acc[0]);
        chk("t1_issue", 32'(bus.unit_valid_in), 32'b0001);
        chk("t1_inflight", 32'(bus.inflight_out), 32'd1);
        tick();
        chk("t1_issue_pulse", 32'(bus.unit_valid_in), 32'd0);
        wait_vo(1, "t1_vo_seen");
        if (vo_cyc.size() >= 1) chk("t1_latency", 32'(vo_cyc[0] - uvo_cyc[0]), 32'd2);
        chk("t1_data", 32'(bus.data_out), 32'h5A);
        tick();
        chk("t1_inflight_zero", 32'(bus.inflight_out), 32'd0);

        // Back-to-back, six windows
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            send(DW'(i), acc[i]);
            if (i == 4) chk("t2_busy_full", 32'(bus.busy_out), 32'd1);
        end
        wait_vo(6, "t2_vo_seen");
        chk("t2_grant_cnt", 32'(grant_log.size()), 32'd6);
        if (grant_log.size() == 6) begin
            chk("t2_g0", 32'(grant_log[0]), 32'd0);
            chk("t2_g1", 32'(grant_log[1]), 32'd1);
            chk("t2_g2", 32'(grant_log[2]), 32'd2);
            chk("t2_g3", 32'(grant_log[3]), 32'd3);
            chk("t2_g4", 32'(grant_log[4]), 32'd0);
            chk("t2_g5", 32'(grant_log[5]), 32'd1);
        end
        if (vo_cyc.size() >= 1) chk("t2_5th_accept", 32'(acc[5]), 32'(vo_cyc[0]));
        tick();
        chk("t2_drained", 32'(exp_q.size()), 32'd0);

        // Out-of-order completion
        do_reset();
        set_lat(20, 5, 5, 5);
        send(8'hA0, acc[0]);
        send(8'hB0, acc[1]);
        send(8'hC0, acc[2]);
        send(8'hD0, acc[3]);
        wait_vo(4, "t3_vo_seen");
        chk("t3_ooo", 32'(uvo_cyc[1] < uvo_cyc[0]), 32'd1);
        if (vo_cyc.size() >= 4) begin
            chk("t3_first_vo", 32'(vo_cyc[0]), 32'(uvo_cyc[0] + 2));
            chk("t3_consecutive", 32'(vo_cyc[3] - vo_cyc[0]), 32'd3);
        end

        // Round-robin skip of an externally busy unit
        do_reset();
        set_lat(8, 8, 8, 8);
        force_busy = 4'b0010;
        send(8'h11, acc[0]);
        send(8'h22, acc[1]);
        send(8'h33, acc[2]);
        wait_vo(3, "t4_vo_seen");
        send(8'h44, acc[3]);
        wait_vo(4, "t4_vo4_seen");
        chk("t4_grant_cnt", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() == 4) begin
            chk("t4_g0", 32'(grant_log[0]), 32'd0);
            chk("t4_g1", 32'(grant_log[1]), 32'd2);
            chk("t4_g2", 32'(grant_log[2]), 32'd3);
            chk("t4_wrap", 32'(grant_log[3]), 32'd0);
        end
        force_busy = '0;

        // Stray strobe
        do_reset();
        stray = 4'b0100;
        tick();
        stray = '0;
        chk("t5_err_set", 32'(bus.err_out), 32'd1);
        chk("t5_no_vo", 32'(bus.valid_out), 32'd0);
        tick(); tick(); tick();
        chk("t5_err_sticky", 32'(bus.err_out), 32'd1);
        chk("t5_no_outputs", 32'(vo_cyc.size()), 32'd0);
        do_reset();
        chk("t5_err_cleared", 32'(bus.err_out), 32'd0);

        // Reset with windows in flight
        set_lat(30, 30, 30, 30);
        send(8'h61, acc[0]);
        send(8'h62, acc[1]);
        send(8'h63, acc[2]);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_vo", 32'(bus.valid_out), 32'd0);
        chk("t6_inflight", 32'(bus.inflight_out), 32'd0);
        chk("t6_busy", 32'(bus.busy_out), 32'd0);
        grant_log.delete();
        send(8'h77, acc[3]);
        chk("t6_regrant", 32'(bus.unit_valid_in), 32'b0001);
        wait_vo(1, "t6_vo_seen");
        chk("t6_data", 32'(bus.data_out), 32'h77);
        for (int i = 0; i < 40; i++) tick();
        chk("t6_single_out", 32'(vo_cyc.size()), 32'd1);
        chk("t6_no_err", 32'(bus.err_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
